// File: rtl/alu_share_arb.sv
// Two-port round-robin arbiter that time-shares one combinational ALU, issuing at most
// one operation per cycle and capturing each result into a per-port valid/ready response slot.
module alu_share_arb #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_req0_valid,
    output logic             o_req0_ready,
    input  logic [3:0]       i_req0_op,
    input  logic [XLEN-1:0]  i_req0_a,
    input  logic [XLEN-1:0]  i_req0_b,
    output logic             o_rsp0_valid,
    input  logic             i_rsp0_ready,
    output logic [XLEN-1:0]  o_rsp0_data,
    output logic             o_rsp0_zero,
    input  logic             i_req1_valid,
    output logic             o_req1_ready,
    input  logic [3:0]       i_req1_op,
    input  logic [XLEN-1:0]  i_req1_a,
    input  logic [XLEN-1:0]  i_req1_b,
    output logic             o_rsp1_valid,
    input  logic             i_rsp1_ready,
    output logic [XLEN-1:0]  o_rsp1_data,
    output logic             o_rsp1_zero,
    output logic [3:0]       o_alu_ctrl,
    output logic [XLEN-1:0]  o_alu_src1,
    output logic [XLEN-1:0]  o_alu_src2,
    input  logic [XLEN-1:0]  i_alu_res,
    input  logic             i_alu_zero,
    output logic [CNT_W-1:0] o_issue_cnt
);

    logic [1:0]      w_req_valid;
    logic [1:0]      w_rsp_ready;
    logic [1:0]      w_elig;
    logic [1:0]      w_grant;
    logic [1:0]      r_rsp_valid;
    logic [1:0]      r_rsp_zero;
    logic [XLEN-1:0] r_rsp_data [2];
    logic            r_rr_ptr;
    logic [CNT_W-1:0] r_issue_cnt;

    assign w_req_valid = {i_req1_valid, i_req0_valid};
    assign w_rsp_ready = {i_rsp1_ready, i_rsp0_ready};

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_port
            // A slot that is draining this cycle can accept a new result on the same edge.
            assign w_elig[gi] = w_req_valid[gi] & (~r_rsp_valid[gi] | w_rsp_ready[gi]);

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_rsp_valid[gi] <= 1'b0;
                    r_rsp_data[gi]  <= '0;
                    r_rsp_zero[gi]  <= 1'b0;
                end else if (w_grant[gi]) begin
                    r_rsp_valid[gi] <= 1'b1;
                    r_rsp_data[gi]  <= i_alu_res;
                    r_rsp_zero[gi]  <= i_alu_zero;
                end else if (w_rsp_ready[gi]) begin
                    r_rsp_valid[gi] <= 1'b0;
                end
            end
        end
    endgenerate

    // Pointer names the preferred port; it only matters when both are eligible.
    assign w_grant[0] = rst_n & w_elig[0] & (~w_elig[1] | ~r_rr_ptr);
    assign w_grant[1] = rst_n & w_elig[1] & (~w_elig[0] |  r_rr_ptr);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rr_ptr    <= 1'b0;
            r_issue_cnt <= '0;
        end else begin
            if (w_elig[0] && w_elig[1]) begin
                r_rr_ptr <= ~r_rr_ptr;
            end
            if (|w_grant) begin
                r_issue_cnt <= r_issue_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
            end
        end
    end

    always_comb begin
        o_alu_ctrl = 4'b0000;
        o_alu_src1 = '0;
        o_alu_src2 = '0;
        if (w_grant[0]) begin
            o_alu_ctrl = i_req0_op;
            o_alu_src1 = i_req0_a;
            o_alu_src2 = i_req0_b;
        end else if (w_grant[1]) begin
            o_alu_ctrl = i_req1_op;
            o_alu_src1 = i_req1_a;
            o_alu_src2 = i_req1_b;
        end
    end

    assign o_req0_ready = w_grant[0];
    assign o_req1_ready = w_grant[1];
    assign o_rsp0_valid = r_rsp_valid[0];
    assign o_rsp1_valid = r_rsp_valid[1];
    assign o_rsp0_data  = r_rsp_data[0];
    assign o_rsp1_data  = r_rsp_data[1];
    assign o_rsp0_zero  = r_rsp_zero[0];
    assign o_rsp1_zero  = r_rsp_zero[1];
    assign o_issue_cnt  = r_issue_cnt;

endmodule

// File: tb/tb_alu_share_arb.sv
// Directed bench for alu_share_arb: expected responses are queued per port at grant time
// and compared when the response slot shows them; a small ALU fixture closes the loop.
module tb_alu_share_arb;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req0_valid = 1'b0, req1_valid = 1'b0;
    logic        req0_ready, req1_ready;
    logic [3:0]  req0_op = 4'd0, req1_op = 4'd0;
    logic [31:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
    logic        rsp0_valid, rsp1_valid;
    logic        rsp0_ready = 1'b1, rsp1_ready = 1'b1;
    logic [31:0] rsp0_data, rsp1_data;
    logic        rsp0_zero, rsp1_zero;
    logic [3:0]  alu_ctrl;
    logic [31:0] alu_src1, alu_src2, alu_res;
    logic        alu_zero;
    logic [15:0] issue_cnt;

    int          checks = 0;
    int          errors = 0;
    logic [15:0] exp_cnt = '0;
    logic [32:0] q0[$];
    logic [32:0] q1[$];

    always #5 clk = ~clk;

    alu_share_arb #(.XLEN(32), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .i_req0_valid(req0_valid), .o_req0_ready(req0_ready), .i_req0_op(req0_op),
        .i_req0_a(req0_a), .i_req0_b(req0_b),
        .o_rsp0_valid(rsp0_valid), .i_rsp0_ready(rsp0_ready),
        .o_rsp0_data(rsp0_data), .o_rsp0_zero(rsp0_zero),
        .i_req1_valid(req1_valid), .o_req1_ready(req1_ready), .i_req1_op(req1_op),
        .i_req1_a(req1_a), .i_req1_b(req1_b),
        .o_rsp1_valid(rsp1_valid), .i_rsp1_ready(rsp1_ready),
        .o_rsp1_data(rsp1_data), .o_rsp1_zero(rsp1_zero),
        .o_alu_ctrl(alu_ctrl), .o_alu_src1(alu_src1), .o_alu_src2(alu_src2),
        .i_alu_res(alu_res), .i_alu_zero(alu_zero), .o_issue_cnt(issue_cnt)
    );

    // ALU fixture standing in for the shared alu instance.
    always_comb begin
        alu_res = '0;
        case (alu_ctrl)
            4'b0000: alu_res = alu_src1 + alu_src2;
            4'b0001: alu_res = alu_src1 - alu_src2;
            4'b0010: alu_res = alu_src1 & alu_src2;
            4'b0011: alu_res = alu_src1 | alu_src2;
            4'b0100: alu_res = alu_src1 << alu_src2[4:0];
            4'b0101: alu_res = {31'd0, $signed(alu_src1) < $signed(alu_src2)};
            4'b0111: alu_res = {31'd0, alu_src1 < alu_src2};
            4'b1000: alu_res = alu_src1 ^ alu_src2;
            default: alu_res = '0;
        endcase
    end
    assign alu_zero = (alu_res == '0);

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock cycle: check visible responses against the queue heads, check grants,
    // queue the results expected from this cycle's grants, then advance past the edge.
    task automatic cyc(input logic er0, input logic er1, input logic [32:0] ex0, input logic [32:0] ex1);
        @(negedge clk);
        chk("issue_cnt", issue_cnt, exp_cnt);
        chk("rsp0_valid", rsp0_valid, q0.size() != 0);
        if (q0.size() != 0) begin
            chk("rsp0_data", rsp0_data, q0[0][32:1]);
            chk("rsp0_zero", rsp0_zero, q0[0][0]);
            if (rsp0_ready) void'(q0.pop_front());
        end
        chk("rsp1_valid", rsp1_valid, q1.size() != 0);
        if (q1.size() != 0) begin
            chk("rsp1_data", rsp1_data, q1[0][32:1]);
            chk("rsp1_zero", rsp1_zero, q1[0][0]);
            if (rsp1_ready) void'(q1.pop_front());
        end
        chk("req0_ready", req0_ready, er0);
        chk("req1_ready", req1_ready, er1);
        if (er0) q0.push_back(ex0);
        if (er1) q1.push_back(ex1);
        if (er0 || er1) exp_cnt = exp_cnt + 16'd1;
        $display("t=%0t cyc gnt0=%0b gnt1=%0b cnt=%0h", $time, req0_ready, req1_ready, issue_cnt);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state, with a request already pending.
        req0_valid = 1'b1;
        #3;
        chk("rst_rsp0_valid", rsp0_valid, 1'b0);
        chk("rst_rsp1_valid", rsp1_valid, 1'b0);
        chk("rst_rsp0_data", rsp0_data, 32'd0);
        chk("rst_cnt", issue_cnt, 16'd0);
        chk("rst_req0_ready", req0_ready, 1'b0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Single add on port 0.
        req0_op = 4'b0000; req0_a = 32'd5; req0_b = 32'd7;
        cyc(1'b1, 1'b0, {32'd12, 1'b0}, '0);
        req0_valid = 1'b0;
        cyc(1'b0, 1'b0, '0, '0);

        // Contention: grants alternate starting with port 0.
        req0_valid = 1'b1; req0_op = 4'b0001; req0_a = 32'd9;    req0_b = 32'd9;
        req1_valid = 1'b1; req1_op = 4'b1000; req1_a = 32'hF0;   req1_b = 32'h0F;
        cyc(1'b1, 1'b0, {32'd0, 1'b1}, '0);
        cyc(1'b0, 1'b1, '0, {32'hFF, 1'b0});
        cyc(1'b1, 1'b0, {32'd0, 1'b1}, '0);
        cyc(1'b0, 1'b1, '0, {32'hFF, 1'b0});
        req0_valid = 1'b0; req1_valid = 1'b0;
        cyc(1'b0, 1'b0, '0, '0);

        // Port 0 consumer stalls; port 1 keeps issuing; release regrants port 0.
        req0_valid = 1'b1; req0_op = 4'b0000; req0_a = 32'd3; req0_b = 32'd4;
        req1_valid = 1'b1; req1_op = 4'b0101; req1_a = 32'hFFFF_FFFF; req1_b = 32'd1;
        rsp0_ready = 1'b0;
        cyc(1'b1, 1'b0, {32'd7, 1'b0}, '0);
        cyc(1'b0, 1'b1, '0, {32'd1, 1'b0});
        cyc(1'b0, 1'b1, '0, {32'd1, 1'b0});
        cyc(1'b0, 1'b1, '0, {32'd1, 1'b0});
        rsp0_ready = 1'b1; req1_valid = 1'b0;
        req0_a = 32'd10; req0_b = 32'd20;
        cyc(1'b1, 1'b0, {32'd30, 1'b0}, '0);
        req0_valid = 1'b0;
        cyc(1'b0, 1'b0, '0, '0);

        // Back-to-back on port 0 alone.
        req0_valid = 1'b1; req0_op = 4'b0100; req0_a = 32'd1; req0_b = 32'd4;
        cyc(1'b1, 1'b0, {32'd16, 1'b0}, '0);
        req0_op = 4'b0111; req0_a = 32'd1; req0_b = 32'hFFFF_FFFF;
        cyc(1'b1, 1'b0, {32'd1, 1'b0}, '0);
        req0_valid = 1'b0;
        cyc(1'b0, 1'b0, '0, '0);

        // Reset while rsp1 is valid and a grant is active.
        req1_valid = 1'b1; req1_op = 4'b1000; req1_a = 32'hF0; req1_b = 32'h0F;
        cyc(1'b0, 1'b1, '0, {32'hFF, 1'b0});
        req0_valid = 1'b1; req0_op = 4'b0000; req0_a = 32'd1; req0_b = 32'd2;
        #2;
        chk("pre_rst_rsp1_valid", rsp1_valid, 1'b1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_rsp1_valid", rsp1_valid, 1'b0);
        chk("mid_rst_rsp0_valid", rsp0_valid, 1'b0);
        chk("mid_rst_cnt", issue_cnt, 16'd0);
        chk("mid_rst_req0_ready", req0_ready, 1'b0);
        chk("mid_rst_req1_ready", req1_ready, 1'b0);
        q0.delete(); q1.delete(); exp_cnt = '0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        cyc(1'b1, 1'b0, {32'd3, 1'b0}, '0);
        cyc(1'b0, 1'b1, '0, {32'hFF, 1'b0});
        req0_valid = 1'b0; req1_valid = 1'b0;
        cyc(1'b0, 1'b0, '0, '0);

        // Counter wrap: run port 0 uncontested up to 0xFFFF grants, then one more.
        req0_valid = 1'b1; req0_op = 4'b0000; req0_a = 32'd0; req0_b = 32'd0;
        for (int i = 0; i < 65535 - int'(exp_cnt); i++) @(posedge clk);
        #1;
        req0_valid = 1'b0;
        exp_cnt = 16'hFFFF;
        q0.delete(); q0.push_back({32'd0, 1'b1});
        cyc(1'b0, 1'b0, '0, '0);
        req0_valid = 1'b1; req0_a = 32'd2; req0_b = 32'd2;
        cyc(1'b1, 1'b0, {32'd4, 1'b0}, '0);
        req0_valid = 1'b0;
        cyc(1'b0, 1'b0, '0, '0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_share_arb.md
Name: alu_share_arb

Overview:
Arbiter that time-shares one combinational alu instance between two requesters: port 0 is the main execute path and port 1 is an auxiliary requester such as the address/branch helper. It performs round-robin issue of one operation per cycle. It drives the alu's alu_ctrl/src1/src2 inputs and captures alu_res/zero into a per-port response register with valid/ready handoff. It also maintains a wrapping count of issued operations.

Parameters:
XLEN, 32, operand/result width (must match alu)
CNT_W, 16, width of issue counter

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
req0_valid  in  1  port 0 request valid
req0_ready  out  1  port 0 request accepted this cycle
req0_op  in  4  port 0 alu_ctrl code
req0_a  in  XLEN  port 0 src1
req0_b  in  XLEN  port 0 src2
rsp0_valid  out  1  port 0 result valid
rsp0_ready  in  1  port 0 consumer takes result
rsp0_data  out  XLEN  port 0 captured alu_res
rsp0_zero  out  1  port 0 captured zero
req1_valid, req1_ready, req1_op, req1_a, req1_b, rsp1_valid, rsp1_ready, rsp1_data, rsp1_zero: same as port 0, for port 1
alu_ctrl  out  4  to alu
alu_src1  out  XLEN  to alu
alu_src2  out  XLEN  to alu
alu_res  in  XLEN  from alu (combinational, same cycle)
alu_zero  in  1  from alu
issue_cnt  out  CNT_W  number of grants since reset, wraps

Behaviour:
- Reset state (async, rst_n low): rsp0_valid=rsp1_valid=0, rsp*_data=0, rsp*_zero=0, issue_cnt=0, rr pointer=port 0 preferred. Reset mid-operation discards any pending result. req*_ready is combinational and is 0 while in reset.
- Eligibility: port i is eligible when reqi_valid && (!rspi_valid || rspi_ready), i.e. its response slot is empty or is draining this cycle.
- Grant: at most one grant per cycle.
  - Only one port eligible: grant that port.
  - Both eligible: grant the port indicated by the rr pointer. Pointer then moves to the other port.
  - Pointer updates only on a contested grant. An uncontested grant leaves it unchanged.
- reqi_ready = granti. This is combinational from valid/ready/pointer and has no dependence on alu_res.
- ALU drive:
  - While a grant is active: alu_ctrl/src1/src2 = granted port's op/a/b.
  - With no grant: alu_ctrl=4'b0000, src1=src2=0.
  - Op codes pass through unchecked. Codes outside {0000,0001,0010,0011,0100,0101,0111,1000} yield whatever the alu returns (0).
- Capture: on the rising edge ending a cycle where port i is granted, rspi_data<=alu_res, rspi_zero<=alu_zero, rspi_valid<=1. Result is visible one cycle after acceptance (latency 1).
- Drain: rspi_valid clears on an edge where rspi_ready=1 and port i is not granted. Simultaneous drain and grant gives back-to-back results with rspi_valid staying 1 and data replaced.
- Hold: while rspi_valid=1 and rspi_ready=0, rspi_data/rspi_zero are stable and port i is ineligible. The other port continues to be served.
- issue_cnt increments by 1 on every grant and wraps from 2^CNT_W-1 to 0.
- Throughput: 1 op/cycle aggregate. Each port sustains 1 op/cycle when uncontested and its consumer holds rsp ready=1.
- No combinational path from rsp*_data to any output.

Test Plan:
- Reset, then only req0 op=0000 a=5 b=7 -> req0_ready=1 same cycle, next cycle rsp0_valid=1, rsp0_data=12, rsp0_zero=0; issue_cnt=1.
- Both ports valid every cycle, rsp ready=1, port0 op=0001 a=9 b=9, port1 op=1000 a=0xF0 b=0x0F -> grants alternate 0,1,0,1 starting with 0. Port0 results show data=0 and zero=1; port1 results show 0xFF and zero=0.
- Port0 rsp0_ready=0 after first result, req0 held valid -> rsp0_data stays stable and req0_ready=0. Port1 ops (op=0101 a=-1 b=1 -> 1) issue every cycle. Release rsp0_ready -> port0 regranted the same cycle.
- Back-to-back on port0 alone with rsp0_ready=1: ops 0100 (a=1 b=4 -> 16) then 0111 (a=1 b=0xFFFFFFFF -> 1) -> rsp0_valid stays 1 for both cycles, data 16 then 1.
- Assert rst_n low while rsp1_valid=1 and a grant is active -> rsp1_valid, rsp0_valid, issue_cnt = 0 immediately. After release, port0 wins the first contested cycle.
- Force issue_cnt to 0xFFFF (CNT_W=16) via 65535 grants, then one more grant -> issue_cnt=0.
